// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding/hazard unit: default parameter values
// and the multiply/divide tracker state encoding.
package hazard_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int NUM_FWD_DEF = 2;
    localparam int MD_LAT_DEF  = 4;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_WAIT = 1'b1
    } md_state_e;

endpackage

// File: rtl/fwd_priority_select.sv
// Priority match of one ALU operand against the forwarding sources; the
// youngest (lowest-index) writing source with a non-zero matching rd wins.
module fwd_priority_select
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF
) (
    input  logic [NUM_FWD-1:0]        src_wr,
    input  logic [NUM_FWD*REG_AW-1:0] src_rd,
    input  logic [REG_AW-1:0]         op_reg,
    output logic [NUM_FWD-1:0]        sel
);

    // Walk oldest to youngest so the youngest match overwrites any older one.
    always_comb begin
        sel = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (src_wr[i] && (src_rd[i*REG_AW +: REG_AW] != '0) &&
                (src_rd[i*REG_AW +: REG_AW] == op_reg)) begin
                sel = '0;
                sel[NUM_FWD-1-i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, load-use and multiply/divide interlock, and a
// saturating count of stalled cycles.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_FWD = NUM_FWD_DEF,
    parameter int MD_LAT  = MD_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_AW-1:0]         ex_rs,
    input  logic [REG_AW-1:0]         ex_rt,
    input  logic [NUM_FWD-1:0]        src_wr,
    input  logic [NUM_FWD*REG_AW-1:0] src_rd,
    input  logic [REG_AW-1:0]         id_rs,
    input  logic [REG_AW-1:0]         id_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      ex_mem_read,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_md_start,
    input  logic                      id_md_use,
    input  logic                      stall_cnt_clr,
    output logic [NUM_FWD-1:0]        fwd_a,
    output logic [NUM_FWD-1:0]        fwd_b,
    output logic                      stall,
    output logic                      md_busy,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int MDC_W = $clog2(MD_LAT);
    localparam logic [MDC_W-1:0] MD_LOAD = MDC_W'(MD_LAT - 1);

    logic [MDC_W-1:0] md_cnt;
    md_state_e        md_state;
    logic             load_hzd;
    logic             md_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    fwd_priority_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_a (
        .src_wr (src_wr),
        .src_rd (src_rd),
        .op_reg (ex_rs),
        .sel    (fwd_a)
    );

    fwd_priority_select #(.REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel_b (
        .src_wr (src_wr),
        .src_rd (src_rd),
        .op_reg (ex_rt),
        .sel    (fwd_b)
    );

    assign load_hzd = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));
    assign md_busy  = ex_md_start || (md_cnt != '0);
    assign md_stall = md_busy && id_md_use;
    assign stall    = load_hzd || md_stall;

    // A new issue always restarts the latency window rather than extending it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt   <= '0;
            md_state <= MD_IDLE;
        end else begin
            if (ex_md_start) begin
                md_cnt <= MD_LOAD;
            end else if (md_cnt != '0) begin
                md_cnt <= md_cnt - MDC_W'(1);
            end
            case (md_state)
                MD_IDLE: if (ex_md_start) md_state <= MD_WAIT;
                MD_WAIT: if (!ex_md_start && (md_cnt == MDC_W'(1))) md_state <= MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, multi-cycle
// sequences and randomized traffic against an abstract reference model.
module tb_fwd_hazard_unit;

    localparam int AW  = 5;
    localparam int NF  = 2;
    localparam int LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [AW-1:0] ex_rs, ex_rt, id_rs, id_rt, ex_rd;
    logic [NF-1:0] src_wr;
    logic [NF*AW-1:0] src_rd;
    logic id_uses_rs, id_uses_rt, ex_mem_read, ex_md_start, id_md_use, stall_cnt_clr;

    logic [NF-1:0] fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic          stall, md_busy, stall4, md_busy4;
    logic [15:0]   stall_cnt;
    logic [3:0]    stall_cnt4;

    fwd_hazard_unit #(.REG_AW(AW), .NUM_FWD(NF), .MD_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .ex_rt(ex_rt), .src_wr(src_wr),
        .src_rd(src_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_md_start(ex_md_start), .id_md_use(id_md_use), .stall_cnt_clr(stall_cnt_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    fwd_hazard_unit #(.REG_AW(AW), .NUM_FWD(NF), .MD_LAT(LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .ex_rt(ex_rt), .src_wr(src_wr),
        .src_rd(src_rd), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_md_start(ex_md_start), .id_md_use(id_md_use), .stall_cnt_clr(stall_cnt_clr),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall(stall4), .md_busy(md_busy4), .stall_cnt(stall_cnt4)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: cycle index, cycle of the most recent accepted issue, counts.
    int cyc = 0;
    int last_issue = -100;
    int m_cnt = 0;
    int m_cnt4 = 0;

    typedef struct {
        logic [1:0]    wr;
        logic [AW-1:0] rd1, rd0, rs, rt;
        logic          mem_read;
        logic [AW-1:0] erd;
        logic          urs, urt;
        logic [AW-1:0] irs, irt;
        logic [1:0]    ea, eb;
        logic          es;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NF-1:0] ref_fwd(input logic [AW-1:0] r);
        for (int i = 0; i < NF; i++) begin
            logic [AW-1:0] d;
            d = src_rd[i*AW +: AW];
            if (src_wr[i] && d != 0 && d == r) return NF'(1) << (NF - 1 - i);
        end
        return '0;
    endfunction

    function automatic logic ref_busy();
        return ex_md_start || (cyc - last_issue < LAT);
    endfunction

    function automatic logic ref_load();
        return ex_mem_read && ex_rd != 0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    function automatic logic ref_stall();
        return ref_load() || (ref_busy() && id_md_use);
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_cnt4 = 0;
        last_issue = -100;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else begin
            if (stall_cnt_clr) begin
                m_cnt = 0;
                m_cnt4 = 0;
            end else if (ref_stall()) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (ex_md_start) last_issue = cyc;
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("fwd_a", 32'(fwd_a), 32'(ref_fwd(ex_rs)));
        chk("fwd_b", 32'(fwd_b), 32'(ref_fwd(ex_rt)));
        chk("stall", 32'(stall), 32'(ref_stall()));
        chk("md_busy", 32'(md_busy), 32'(ref_busy()));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("stall_cnt_w4", 32'(stall_cnt4), 32'(m_cnt4));
        chk("md_busy_w4", 32'(md_busy4), 32'(ref_busy()));
        chk("stall_w4", 32'(stall4), 32'(ref_stall()));
    endtask

    task automatic edge_step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        edge_step();
    endtask

    task automatic clear_inputs();
        ex_rs = '0; ex_rt = '0; id_rs = '0; id_rt = '0; ex_rd = '0;
        src_wr = '0; src_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_md_start = 1'b0; id_md_use = 1'b0; stall_cnt_clr = 1'b0;
    endtask

    task automatic set_load_hzd();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_uses_rt = 1'b1; id_rt = 5'd8;
    endtask

    int base;

    initial begin
        tbl[0]  = '{2'b11, 5'd3, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0};
        tbl[1]  = '{2'b10, 5'd3, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0};
        tbl[2]  = '{2'b01, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        tbl[3]  = '{2'b11, 5'd5, 5'd9, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b01, 2'b10, 1'b0};
        tbl[4]  = '{2'b00, 5'd4, 5'd4, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        tbl[5]  = '{2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        tbl[6]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b1, 5'd0, 5'd8, 2'b00, 2'b00, 1'b1};
        tbl[7]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd2, 5'd8, 2'b00, 2'b00, 1'b0};
        tbl[8]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd8, 5'd0, 2'b00, 2'b00, 1'b0};
        tbl[10] = '{2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 5'd12, 5'd0, 2'b00, 2'b00, 1'b1};
        tbl[11] = '{2'b11, 5'd6, 5'd6, 5'd6, 5'd6, 1'b1, 5'd6, 1'b0, 1'b1, 5'd0, 5'd6, 2'b10, 2'b10, 1'b1};

        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset md_busy", 32'(md_busy), 32'd0);
        rst_n = 1'b1;

        // Directed vector table, unit idle.
        for (int v = 0; v < 12; v++) begin
            clear_inputs();
            src_wr = tbl[v].wr; src_rd = {tbl[v].rd1, tbl[v].rd0};
            ex_rs = tbl[v].rs; ex_rt = tbl[v].rt;
            ex_mem_read = tbl[v].mem_read; ex_rd = tbl[v].erd;
            id_uses_rs = tbl[v].urs; id_uses_rt = tbl[v].urt;
            id_rs = tbl[v].irs; id_rt = tbl[v].irt;
            @(negedge clk);
            chk($sformatf("vec%0d fwd_a", v), 32'(fwd_a), 32'(tbl[v].ea));
            chk($sformatf("vec%0d fwd_b", v), 32'(fwd_b), 32'(tbl[v].eb));
            chk($sformatf("vec%0d stall", v), 32'(stall), 32'(tbl[v].es));
            check_all();
            edge_step();
        end
        chk("table stall_cnt", 32'(stall_cnt), 32'd3);

        // Single issue with dependent ID held: busy/stall for LAT cycles.
        clear_inputs();
        id_md_use = 1'b1;
        base = m_cnt;
        for (int k = 0; k <= LAT; k++) begin
            ex_md_start = (k == 0);
            @(negedge clk);
            chk($sformatf("md k%0d busy", k), 32'(md_busy), 32'(k < LAT));
            chk($sformatf("md k%0d stall", k), 32'(stall), 32'(k < LAT));
            check_all();
            edge_step();
        end
        chk("md stall_cnt", 32'(stall_cnt), 32'(base + LAT));

        // Re-issue while busy restarts the window.
        for (int k = 0; k <= LAT + 2; k++) begin
            ex_md_start = (k == 0 || k == 2);
            @(negedge clk);
            chk($sformatf("restart k%0d busy", k), 32'(md_busy), 32'(k < LAT + 2));
            check_all();
            edge_step();
        end

        // Load hazard and md stall together count once.
        clear_inputs();
        set_load_hzd();
        ex_md_start = 1'b1; id_md_use = 1'b1;
        base = m_cnt;
        @(negedge clk);
        chk("both stall", 32'(stall), 32'd1);
        check_all();
        edge_step();
        chk("both stall_cnt", 32'(stall_cnt), 32'(base + 1));
        clear_inputs();
        for (int k = 0; k < LAT; k++) tick();

        // Long stall run saturates the narrow counter.
        base = m_cnt;
        set_load_hzd();
        for (int k = 0; k < 20; k++) tick();
        chk("sat w4", 32'(stall_cnt4), 32'd15);
        chk("sat w16", 32'(stall_cnt), 32'(base + 20));

        // Clear wins over increment.
        stall_cnt_clr = 1'b1;
        tick();
        chk("clr stall_cnt", 32'(stall_cnt), 32'd0);
        chk("clr stall_cnt_w4", 32'(stall_cnt4), 32'd0);
        stall_cnt_clr = 1'b0;
        tick();
        chk("post clr stall_cnt", 32'(stall_cnt), 32'd1);

        // Asynchronous reset mid-operation.
        clear_inputs();
        ex_md_start = 1'b1; id_md_use = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick();
        chk("pre-rst busy", 32'(md_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst busy", 32'(md_busy), 32'd0);
        chk("async rst stall_cnt", 32'(stall_cnt), 32'd0);
        chk("async rst stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick();
        chk("post rst busy", 32'(md_busy), 32'd1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            src_wr = NF'($urandom_range(0, 3));
            src_rd = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
            ex_rs = AW'($urandom_range(0, 3)); ex_rt = AW'($urandom_range(0, 3));
            id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
            ex_rd = AW'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom_range(0, 1)); id_uses_rt = 1'($urandom_range(0, 1));
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_md_start = ($urandom_range(0, 7) == 0);
            id_md_use = 1'($urandom_range(0, 1));
            stall_cnt_clr = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
